// File: rtl/golomb_pkg.sv
// Shared widths and state encoding for the serial Golomb-Rice decoder.
package golomb_pkg;
  localparam int BS_W  = 32;  // packed bitstream word
  localparam int N_W   = 9;   // decoded value output
  localparam int M_W   = 3;   // Rice parameter
  localparam int Q_W   = 5;   // unary quotient counter
  localparam int CNT_W = 6;   // bits-left counter (0..32)
  localparam int R_W   = 7;   // remainder register, holds up to 2^M_W-1 bits

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNARY = 2'd1,
    REM   = 2'd2
  } state_t;
endpackage

// File: rtl/golomb_decoding.sv
// Serial Golomb-Rice decoder: walks a loaded 32-bit word MSB-first, one bit
// per clock, and emits n = (q << m) + r with a one-cycle ready strobe for
// every complete codeword. A codeword cut off by the end of the word is
// dropped without a strobe.
// Optional build macro GOLOMB_DEC_OVF_EN adds an overflow flag output that
// marks emitted values whose untruncated result exceeds the 9-bit range.
module golomb_decoding
  import golomb_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [BS_W-1:0] Bitstream,
  input  logic            validin,
  input  logic [M_W-1:0]  m,
  output logic            ready,
  output logic [N_W-1:0]  n
`ifdef GOLOMB_DEC_OVF_EN
  ,
  output logic            overflow
`endif
);

  // Value assembly width: wide enough to see the true value when overflow is
  // reported, otherwise the output width so the sum wraps mod 512 directly.
`ifdef GOLOMB_DEC_OVF_EN
  localparam int VAL_W = Q_W + (1 << M_W) - 1 + 1;
`else
  localparam int VAL_W = N_W;
`endif

  state_t            state_q, state_d;
  logic [BS_W-1:0]   sr_q, sr_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [Q_W-1:0]    q_q, q_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [M_W-1:0]    rcnt_q, rcnt_d;
  logic              ready_q, ready_d;
  logic [N_W-1:0]    n_q, n_d;

  logic              bit_in;
  logic [R_W-1:0]    r_shift;
  logic              emit;
  logic [R_W-1:0]    emit_r;
  logic [VAL_W-1:0]  value;

  assign bit_in  = sr_q[BS_W-1];
  assign r_shift = {r_q[R_W-2:0], bit_in};

  // Next-state, datapath updates and emit decision for the bit being consumed.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    m_d     = m_q;
    left_d  = left_q;
    q_d     = q_q;
    r_d     = r_q;
    rcnt_d  = rcnt_q;
    emit    = 1'b0;
    emit_r  = r_q;
    case (state_q)
      IDLE: begin
        if (validin) begin
          sr_d    = Bitstream;
          m_d     = m;
          left_d  = CNT_W'(BS_W);
          q_d     = '0;
          r_d     = '0;
          rcnt_d  = '0;
          state_d = UNARY;
        end
      end
      UNARY: begin
        sr_d   = sr_q << 1;
        left_d = left_q - CNT_W'(1);
        if (!bit_in) begin
          q_d = q_q + Q_W'(1);
        end else if (m_q == '0) begin
          // Zero-length remainder: the terminating 1 completes the codeword.
          emit   = 1'b1;
          emit_r = '0;
          q_d    = '0;
        end else begin
          rcnt_d  = m_q;
          state_d = REM;
        end
        if (left_q == CNT_W'(1)) state_d = IDLE;
      end
      REM: begin
        sr_d   = sr_q << 1;
        left_d = left_q - CNT_W'(1);
        r_d    = r_shift;
        rcnt_d = rcnt_q - M_W'(1);
        if (rcnt_q == M_W'(1)) begin
          emit    = 1'b1;
          emit_r  = r_shift;
          q_d     = '0;
          r_d     = '0;
          state_d = UNARY;
        end
        if (left_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    value   = (VAL_W'(q_q) << m_q) + VAL_W'(emit_r);
    ready_d = emit;
    n_d     = emit ? value[N_W-1:0] : n_q;
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      m_q     <= '0;
      left_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      rcnt_q  <= '0;
      ready_q <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      m_q     <= m_d;
      left_q  <= left_d;
      q_q     <= q_d;
      r_q     <= r_d;
      rcnt_q  <= rcnt_d;
      ready_q <= ready_d;
      n_q     <= n_d;
    end
  end

  assign ready = ready_q;
  assign n     = n_q;

`ifdef GOLOMB_DEC_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow flag refreshed alongside every emitted value.
  always_comb begin
    ovf_d = ovf_q;
    if (emit) ovf_d = (value > VAL_W'((1 << N_W) - 1));
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_golomb_decoding.sv
// Directed self-checking bench for golomb_decoding.
module tb_golomb_decoding;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] Bitstream;
  logic        validin;
  logic [2:0]  m;
  logic        ready;
  logic [8:0]  n;
`ifdef GOLOMB_DEC_OVF_EN
  logic        overflow;
`endif

  golomb_decoding dut (
    .clk       (clk),
    .rstn      (rstn),
    .Bitstream (Bitstream),
    .validin   (validin),
    .m         (m),
    .ready     (ready),
    .n         (n)
`ifdef GOLOMB_DEC_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         exp_cnt;
  int         exp_edge [32];
  int         exp_val  [32];
  bit         exp_ovf  [32];
  logic [8:0] cur_n;

  // Load one word at the next edge (E0) and check ready/n on every edge E1..E32.
  task automatic run_word(input logic [31:0] bs, input logic [2:0] mm,
                          input bit noise, input string tag);
    int idx = 0;
    @(negedge clk);
    Bitstream = bs;
    m         = mm;
    validin   = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      Bitstream = ~bs;
      m         = mm + 3'd1;
    end else begin
      validin = 1'b0;
    end
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      checks++;
      if (idx < exp_cnt && exp_edge[idx] == k) begin
        if (ready !== 1'b1 || n !== 9'(exp_val[idx])) begin
          errors++;
          $display("FAIL %s pulse@E%0d: ready=%b n=%0d, required ready=1 n=%0d",
                   tag, k, ready, n, exp_val[idx]);
        end
`ifdef GOLOMB_DEC_OVF_EN
        checks++;
        if (overflow !== exp_ovf[idx]) begin
          errors++;
          $display("FAIL %s overflow@E%0d: got %b, required %b", tag, k, overflow, exp_ovf[idx]);
        end
`endif
        cur_n = 9'(exp_val[idx]);
        idx++;
      end else begin
        if (ready !== 1'b0 || n !== cur_n) begin
          errors++;
          $display("FAIL %s quiet@E%0d: ready=%b n=%0d, required ready=0 n=%0d",
                   tag, k, ready, n, cur_n);
        end
      end
    end
    validin   = 1'b0;
    Bitstream = bs;
    m         = mm;
  endtask

  // No strobes and n holding for a number of cycles.
  task automatic idle_check(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || n !== cur_n) begin
        errors++;
        $display("FAIL %s idle cycle %0d: ready=%b n=%0d, required ready=0 n=%0d",
                 tag, k, ready, n, cur_n);
      end
    end
  endtask

  task automatic set_vec1();
    exp_cnt = 4;
    exp_edge[0] = 7;  exp_val[0] = 29; exp_ovf[0] = 1'b0;
    exp_edge[1] = 15; exp_val[1] = 38; exp_ovf[1] = 1'b0;
    exp_edge[2] = 24; exp_val[2] = 40; exp_ovf[2] = 1'b0;
    exp_edge[3] = 32; exp_val[3] = 33; exp_ovf[3] = 1'b0;
  endtask

  task automatic test_reset();
    rstn      = 1'b1;
    validin   = 1'b0;
    Bitstream = '0;
    m         = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || n !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b n=%0d, required ready=0 n=0", ready, n);
    end
`ifdef GOLOMB_DEC_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b, required 0", overflow);
    end
`endif
    @(negedge clk);
    rstn  = 1'b0;
    cur_n = 9'd0;
    idle_check(3, "reset_idle");
  endtask

  task automatic test_basic();
    set_vec1();
    run_word(32'b0001101_00001110_000001000_00001001, 3'd3, 1'b0, "basic_m3");
  endtask

  task automatic test_all_ones();
    exp_cnt = 32;
    for (int i = 0; i < 32; i++) begin
      exp_edge[i] = i + 1;
      exp_val[i]  = 0;
      exp_ovf[i]  = 1'b0;
    end
    run_word(32'hFFFF_FFFF, 3'd0, 1'b0, "ones_m0");
  endtask

  task automatic test_overflow();
    exp_cnt = 1;
    exp_edge[0] = 12; exp_val[0] = 127; exp_ovf[0] = 1'b1;
    run_word({12'b00001_1111111, 20'b0}, 3'd7, 1'b0, "wrap_m7");
  endtask

  task automatic test_ignore_validin();
    set_vec1();
    run_word(32'b0001101_00001110_000001000_00001001, 3'd3, 1'b1, "busy_load");
  endtask

  task automatic test_back_to_back();
    exp_cnt = 1;
    exp_edge[0] = 3; exp_val[0] = 0; exp_ovf[0] = 1'b0;
    run_word({3'b100, 29'b0}, 3'd2, 1'b0, "partial_m2");
    idle_check(5, "after_partial");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Bitstream = 32'b0001101_00001110_000001000_00001001;
    m         = 3'd3;
    validin   = 1'b1;
    @(posedge clk); #1;
    validin = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || n !== 9'd29) begin
      errors++;
      $display("FAIL mid_first_pulse: ready=%b n=%0d, required ready=1 n=29", ready, n);
    end
    @(posedge clk); #2;
    rstn = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || n !== 9'd0) begin
      errors++;
      $display("FAIL mid_async_reset: ready=%b n=%0d, required ready=0 n=0", ready, n);
    end
    cur_n = 9'd0;
    idle_check(3, "mid_in_reset");
    @(negedge clk);
    rstn = 1'b0;
    idle_check(40, "mid_after_release");
    set_vec1();
    run_word(32'b0001101_00001110_000001000_00001001, 3'd3, 1'b0, "reload_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_overflow();
    test_ignore_validin();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/golomb_decoding.md
# golomb_decoding

Serial Golomb-Rice decoder. Loads a 32-bit word of concatenated Rice codewords and walks it MSB-first, one bit per clock. Each codeword is a unary quotient (zeros terminated by a 1) followed by an m-bit binary remainder. For every complete codeword it emits the decoded value n = q·2^m + r with a one-cycle `ready` strobe. It sits downstream of the bitstream buffer in the image decompression path.

## Interface
- Parameters: none. Widths are fixed by the shared package.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-high reset. Asserted when `rstn`=1.
- `Bitstream` input 32: packed codewords; bit 31 is decoded first.
- `validin` input 1: load strobe, sampled only in IDLE.
- `m` input 3: Rice parameter k (divisor 2^m), range 0..7.
- `ready` output 1: one-cycle pulse, `n` holds a new value.
- `n` output 9: decoded value; holds between pulses.

## Operation
- States: IDLE, UNARY, REM.
- **IDLE:**
  - `validin`=1 loads `Bitstream` into a 32-bit shift register, latches `m`, sets bits-left=32, clears q and r, and moves to UNARY.
  - `validin`=0 stays in IDLE.
- **UNARY:** each cycle shifts out the MSB and decrements bits-left.
  - Bit 0: q++. q is 5 bits; at most 31 zeros are possible.
  - Bit 1 with latched m=0: emit immediately and stay in UNARY with q cleared.
  - Bit 1 with m>0: go to REM with remainder-count=m.
- **REM:** each cycle shifts the MSB into r (r = {r, bit}) and decrements bits-left.
  - After the m-th bit: emit, clear q and r, return to UNARY.
- **Emit:** register n = ((q << m) + r) truncated to 9 bits, and assert `ready` for one cycle.
- **Exhaustion:** when bits-left reaches 0, go to IDLE on that same edge. A codeword that completes on the last bit is still emitted. A partial codeword (unterminated unary or short remainder) is discarded silently, with no `ready`.
- `validin` outside IDLE is ignored. Changes to `Bitstream` and `m` after load have no effect.
- Reset (at any time, including mid-word) forces IDLE, `ready`=0, `n`=0, and clears the shift register and counters.

## Timing
- Load edge E0 is the edge where IDLE samples `validin`=1.
- A codeword of length L = q+1+m is completed by its last consumed bit at edge E(sum of lengths so far). `ready` and `n` are registered on that edge and visible in the following cycle.
- Codewords decode back-to-back with no idle cycles, so `ready` pulses are spaced by codeword length.
- A word occupies exactly 32 cycles after load. The earliest next load is at E33 (IDLE sampled at E33).
- `ready` is never high for two consecutive cycles unless consecutive codewords have L=1 (m=0, bit 1).

## Configuration
- `GOLOMB_DEC_OVF_EN` defined:
  - Adds output `overflow` (1 bit, reset 0), registered with each emit.
  - `overflow`=1 when the untruncated q·2^m + r exceeds 511, else 0.
- Undefined: no `overflow` port; values above 511 silently wrap mod 512.

## Structure
- Package `golomb_pkg` holds:
  - BS_W=32, N_W=9, M_W=3, Q_W=5, CNT_W=6.
  - The state enum {IDLE, UNARY, REM}.
- Single module. No sub-module is needed; the value assembly (shift+add) is an inline combinational expression.

## Test plan
- m=3, Bitstream=32'b0001101_00001110_000001000_00001001, one-cycle `validin` → four `ready` pulses with n = 29, 38, 40, 33, at E7, E15, E24, E32 after load; IDLE afterwards.
- m=0, Bitstream=32'hFFFF_FFFF → 32 consecutive `ready` cycles, n=0 each.
- m=7, Bitstream=32'b00001_1111111 followed by 20 zeros → one pulse, n=127 (639 mod 512), `overflow`=1 when enabled; the trailing zeros produce no pulse.
- `validin` re-asserted with a different `Bitstream` while decoding the first vector → outputs identical to the first vector alone.
- `rstn` raised mid-word after the first pulse → `ready`=0 and `n`=0 immediately; no further pulses until a new load after release.
- m=2, Bitstream=32'b1_00 followed by 29 zeros → one pulse, n=0, then IDLE at E32 with no further pulses.
